// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/branch request bus into the hazard controller and its stall/flush mask outputs.
// master = hazard detector side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int SIDX_W     = 3,
    parameter int CNT_W      = 4
);
    logic                  hazard_req;
    logic [SIDX_W-1:0]     hazard_stage;
    logic [CNT_W-1:0]      hazard_cycles;
    logic                  branch_taken;
    logic [SIDX_W-1:0]     branch_stage;
    logic [NUM_STAGES-1:0] stall_vec;
    logic [NUM_STAGES-1:0] flush_vec;
    logic                  busy;
    logic [CNT_W-1:0]      stall_rem;

    modport master (
        output hazard_req, hazard_stage, hazard_cycles, branch_taken, branch_stage,
        input  stall_vec, flush_vec, busy, stall_rem
    );

    modport slave (
        input  hazard_req, hazard_stage, hazard_cycles, branch_taken, branch_stage,
        output stall_vec, flush_vec, busy, stall_rem
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush mask generator with multi-cycle stalls, request merging and
// branch-cancels-stall priority. Optional perf counters via `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int SIDX_W     = 3,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events,
`endif
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    function automatic logic idx_valid(input logic [SIDX_W-1:0] idx);
        return (32'(idx) < 32'(NUM_STAGES));
    endfunction

    // Bits [0..stage] set: every stage up to and including the hazard stage holds.
    function automatic logic [NUM_STAGES-1:0] upto_mask(input logic [SIDX_W-1:0] stage);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (32'(i) <= 32'(stage));
        end
        return m;
    endfunction

    function automatic logic [NUM_STAGES-1:0] below_mask(input logic [SIDX_W-1:0] stage);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (32'(i) < 32'(stage));
        end
        return m;
    endfunction

    // Bubble goes into the stage just downstream of the held one; none past writeback.
    function automatic logic [NUM_STAGES-1:0] bubble_mask(input logic [SIDX_W-1:0] stage);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (32'(i) == (32'(stage) + 32'd1));
        end
        return m;
    endfunction

    state_t                r_state;
    logic [SIDX_W-1:0]     r_stage;
    logic [CNT_W-1:0]      r_rem;
    logic [NUM_STAGES-1:0] r_stall_vec;
    logic [NUM_STAGES-1:0] r_flush_vec;

    state_t                w_state_nxt;
    logic                  w_hz_valid;
    logic                  w_br_valid;
    logic [CNT_W-1:0]      w_hz_len;
    logic [CNT_W-1:0]      w_rem_dec;
    logic                  w_act;
    logic [SIDX_W-1:0]     w_stage;
    logic [CNT_W-1:0]      w_rem;
    logic [NUM_STAGES-1:0] w_br_flush;
    logic [NUM_STAGES-1:0] w_flush_nxt;
    logic [NUM_STAGES-1:0] w_stall_nxt;
    logic [CNT_W-1:0]      w_rem_nxt;

    // Next-state and next-mask computation for the stall sequencer.
    always_comb begin
        w_hz_valid  = bus.hazard_req && idx_valid(bus.hazard_stage);
        w_br_valid  = bus.branch_taken && idx_valid(bus.branch_stage);
        w_hz_len    = (bus.hazard_cycles == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : bus.hazard_cycles;
        w_rem_dec   = r_rem - CNT_W'(1'b1);
        w_act       = 1'b0;
        w_stage     = r_stage;
        w_rem       = {CNT_W{1'b0}};
        w_br_flush  = {NUM_STAGES{1'b0}};
        w_state_nxt = ST_IDLE;
        w_flush_nxt = {NUM_STAGES{1'b0}};
        w_stall_nxt = {NUM_STAGES{1'b0}};
        w_rem_nxt   = {CNT_W{1'b0}};

        case (r_state)
            ST_IDLE: begin
                if (w_hz_valid) begin
                    w_act   = 1'b1;
                    w_stage = bus.hazard_stage;
                    w_rem   = w_hz_len;
                end else begin
                    w_act   = 1'b0;
                end
            end
            ST_STALL: begin
                if (w_hz_valid) begin
                    // Max of two CNT_W values cannot exceed all-ones, so the merge saturates naturally.
                    w_act   = 1'b1;
                    w_stage = (bus.hazard_stage > r_stage) ? bus.hazard_stage : r_stage;
                    w_rem   = (w_rem_dec > w_hz_len) ? w_rem_dec : w_hz_len;
                end else if (r_rem > CNT_W'(1'b1)) begin
                    w_act   = 1'b1;
                    w_rem   = w_rem_dec;
                end else begin
                    w_act   = 1'b0;
                end
            end
            default: begin
                w_act = 1'b0;
            end
        endcase

        if (w_br_valid) begin
            w_br_flush = below_mask(bus.branch_stage);
            if (w_act && (w_stage < bus.branch_stage)) begin
                w_act = 1'b0;
            end else begin
                w_act = w_act;
            end
        end else begin
            w_br_flush = {NUM_STAGES{1'b0}};
        end

        if (w_act) begin
            w_state_nxt = ST_STALL;
            w_flush_nxt = w_br_flush | bubble_mask(w_stage);
            w_stall_nxt = upto_mask(w_stage) & ~w_flush_nxt;
            w_rem_nxt   = w_rem;
        end else begin
            w_state_nxt = ST_IDLE;
            w_flush_nxt = w_br_flush;
            w_stall_nxt = {NUM_STAGES{1'b0}};
            w_rem_nxt   = {CNT_W{1'b0}};
        end
    end

    // State, latched stage, remaining count and output mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_stage     <= {SIDX_W{1'b0}};
            r_rem       <= {CNT_W{1'b0}};
            r_stall_vec <= {NUM_STAGES{1'b0}};
            r_flush_vec <= {NUM_STAGES{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_stage     <= w_stage;
            r_rem       <= w_rem_nxt;
            r_stall_vec <= w_stall_nxt;
            r_flush_vec <= w_flush_nxt;
        end
    end

    assign bus.stall_vec = r_stall_vec;
    assign bus.flush_vec = r_flush_vec;
    assign bus.busy      = (r_state == ST_STALL);
    assign bus.stall_rem = r_rem;

`ifdef HAZARD_PERF_CNT_EN
    logic        r_br_flush_nz;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating event counters aligned with the registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_br_flush_nz <= 1'b0;
            r_perf_stall  <= 32'd0;
            r_perf_flush  <= 32'd0;
        end else begin
            r_br_flush_nz <= |w_br_flush;
            if ((r_state == ST_STALL) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end else begin
                r_perf_stall <= r_perf_stall;
            end
            if (r_br_flush_nz && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end else begin
                r_perf_flush <= r_perf_flush;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_events = r_perf_flush;
`endif

endmodule
